// File: rtl/inst_line_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_line_responder_pkg
// Description : Shared widths, FSM encodings and line-address helper for the
//               instruction-line responder.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_line_responder_pkg;

  localparam int C_LINE_INDEX_W = 8;
  localparam int C_PTAG_W       = 20;
  localparam int C_LINE_DATA_W  = 128;
  localparam int C_WORD_W       = 32;
  localparam int C_LINE_WORDS   = 4;

  localparam logic [2:0] C_ST_IDLE = 3'd0;
  localparam logic [2:0] C_ST_TAG  = 3'd1;
  localparam logic [2:0] C_ST_MREQ = 3'd2;
  localparam logic [2:0] C_ST_BEAT = 3'd3;
  localparam logic [2:0] C_ST_RESP = 3'd4;

  // Physical line address: tag above the 8-bit line index, 16-byte aligned.
  function automatic logic [31:0] line_addr(
    input logic [C_PTAG_W-1:0]       tag,
    input logic [C_LINE_INDEX_W-1:0] index
  );
    return {tag, index, 4'b0000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_line_responder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : inst_line_buffer
// Description : Four-word fill buffer with beat counter; full flags the beat
//               that completes the line.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_line_buffer
  import inst_line_responder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     valid,
  input  logic [C_WORD_W-1:0]      data,
  output logic [C_LINE_DATA_W-1:0] line,
  output logic                     full
);

  logic [1:0]          r_cnt;
  logic [C_WORD_W-1:0] r_word [C_LINE_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 2'd0;
      for (int i = 0; i < C_LINE_WORDS; i++) begin
        r_word[i] <= '0;
      end
    end else if (clear) begin
      r_cnt <= 2'd0;
    end else if (valid) begin
      r_word[r_cnt] <= data;
      r_cnt         <= r_cnt + 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < C_LINE_WORDS; gi++) begin : g_line
      assign line[gi*C_WORD_W +: C_WORD_W] = r_word[gi];
    end
  endgenerate

  assign full = valid && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/inst_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : inst_line_responder
// Description : Single-outstanding instruction-line fetch responder: index,
//               then tag, four memory beats, one 128-bit response.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_line_responder
  import inst_line_responder_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_req,
  input  logic                      inst_wr,
  input  logic [1:0]                inst_size,
  input  logic [C_LINE_INDEX_W-1:0] inst_index,
  input  logic [31:0]               inst_wdata,
  output logic                      inst_index_ok,
  input  logic [C_PTAG_W-1:0]       inst_tag,
  input  logic                      flush_i,
  output logic [C_LINE_DATA_W-1:0]  inst_rdata,
  output logic                      inst_data_ok,
  output logic                      mem_rd_req,
  output logic [31:0]               mem_rd_addr,
  input  logic                      mem_rd_addr_ok,
  input  logic                      mem_rd_valid,
  input  logic [C_WORD_W-1:0]       mem_rd_data
);

  logic [2:0]                r_state;
  logic [2:0]                w_state_nxt;
  logic [C_LINE_INDEX_W-1:0] r_index;
  logic [31:0]               r_addr;
  logic                      r_drop;
  logic                      w_accept;
  logic                      w_clear;
  logic                      w_beat_valid;
  logic                      w_full;
  logic [C_LINE_DATA_W-1:0]  w_line;
  logic                      w_unused_ok;

  // The bus is read-only, fixed-size; these fields carry no information.
  assign w_unused_ok = ^{inst_wr, inst_size, inst_wdata};

  assign w_accept = rst && inst_req && !flush_i &&
                    ((r_state == C_ST_IDLE) || (r_state == C_ST_RESP));
  assign w_clear      = (r_state == C_ST_MREQ) && mem_rd_addr_ok;
  assign w_beat_valid = (r_state == C_ST_BEAT) && mem_rd_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: if (w_accept) w_state_nxt = C_ST_TAG;
      C_ST_TAG:  w_state_nxt = flush_i ? C_ST_IDLE : C_ST_MREQ;
      C_ST_MREQ: if (mem_rd_addr_ok) w_state_nxt = C_ST_BEAT;
      C_ST_BEAT: if (w_full) w_state_nxt = C_ST_RESP;
      C_ST_RESP: w_state_nxt = w_accept ? C_ST_TAG : C_ST_IDLE;
      default:   w_state_nxt = C_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= C_ST_IDLE;
      r_index <= '0;
      r_addr  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_index <= inst_index;
      end
      if (r_state == C_ST_TAG) begin
        r_addr <= line_addr(inst_tag, r_index);
      end
      // A flushed fetch still drains its memory beats; only the reply is muted.
      if (r_state == C_ST_RESP) begin
        r_drop <= 1'b0;
      end else if (flush_i && ((r_state == C_ST_MREQ) || (r_state == C_ST_BEAT))) begin
        r_drop <= 1'b1;
      end
    end
  end

  inst_line_buffer u_line_buffer (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .valid (w_beat_valid),
    .data  (mem_rd_data),
    .line  (w_line),
    .full  (w_full)
  );

  assign inst_index_ok = w_accept;
  assign inst_data_ok  = (r_state == C_ST_RESP) && !r_drop;
  assign inst_rdata    = w_line;
  assign mem_rd_req    = (r_state == C_ST_MREQ);
  assign mem_rd_addr   = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_inst_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_line_responder
// Description : Self-checking bench: directed fetch scenarios plus random
//               traffic against a transaction-level fetch/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_line_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inst_req = 1'b0;
  logic         inst_wr = 1'b0;
  logic [1:0]   inst_size = 2'b11;
  logic [7:0]   inst_index = '0;
  logic [31:0]  inst_wdata = '0;
  logic         inst_index_ok;
  logic [19:0]  inst_tag = '0;
  logic         flush_i = 1'b0;
  logic [127:0] inst_rdata;
  logic         inst_data_ok;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_addr_ok = 1'b0;
  logic         mem_rd_valid = 1'b0;
  logic [31:0]  mem_rd_data = '0;

  inst_line_responder dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_index     (inst_index),
    .inst_wdata     (inst_wdata),
    .inst_index_ok  (inst_index_ok),
    .inst_tag       (inst_tag),
    .flush_i        (flush_i),
    .inst_rdata     (inst_rdata),
    .inst_data_ok   (inst_data_ok),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_addr_ok (mem_rd_addr_ok),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory contents are a fixed function of the byte address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} + 32'h1357_9BDF;
  endfunction

  function automatic logic [127:0] expected_line(input logic [31:0] a);
    return {memword(a + 32'd12), memword(a + 32'd8), memword(a + 32'd4), memword(a)};
  endfunction

  // Transaction model: the one accepted fetch and what has happened to it.
  bit          pend_valid = 0, pend_killed = 0, pend_no_mem = 0, pend_mem_done = 0;
  int          pend_acc = 0;
  logic [31:0] pend_addr = '0;
  logic [19:0] cur_tag = '0;
  bit          acc_prev = 0;
  // Memory responder state.
  bit          mreq_active = 0, hold_prev = 0;
  int          addr_wait = 0, beats_left = 0, beat_idx = 0;
  logic [31:0] mem_base = '0, prev_addr = '0;
  // Bookkeeping.
  int          cyc = 0, resp_cnt = 0, acc_cnt = 0, last_beat_cyc = 0, last_lat = 0;
  int          hs_cyc = 0, last_acc_cyc = 0, b2b_hits = 0;
  bit          last_idx_ok = 0;
  logic [127:0] last_rdata = '0;
  // Stimulus knobs.
  int          req_left = 0, addr_delay_cfg = 0, gap_prob = 0, flush_prob = 0;
  bit          rand_req = 0, auto_inc = 0, use_fixed_tag = 0, rand_mem = 0;
  bit          flush_now = 0, flush_at_beat1 = 0, gap_once = 0;
  logic [7:0]  next_index = '0;
  logic [19:0] fixed_tag = '0;

  function automatic bit busy();
    return pend_valid && (!pend_killed ||
           (!pend_no_mem && !(pend_mem_done && beats_left == 0)));
  endfunction

  task automatic cycle();
    bit gap;
    @(negedge clk);
    if (mem_rd_req && !mreq_active) begin
      mreq_active = 1;
      addr_wait = rand_mem ? int'($urandom_range(0, 3)) : addr_delay_cfg;
    end
    mem_rd_addr_ok = 1'b0;
    if (mem_rd_req) begin
      if (addr_wait == 0) mem_rd_addr_ok = 1'b1;
      else addr_wait--;
    end
    mem_rd_valid = 1'b0;
    mem_rd_data  = $urandom;
    if (beats_left > 0) begin
      gap = 0;
      if (gap_once && beat_idx == 2) begin gap = 1; gap_once = 0; end
      else if (rand_mem && int'($urandom_range(0, 99)) < gap_prob) gap = 1;
      if (!gap) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = memword(mem_base + 32'(beat_idx * 4));
      end
    end
    inst_req   = rand_req ? ($urandom_range(0, 99) < 60) : (req_left > 0);
    inst_index = rand_req ? 8'($urandom) : next_index;
    inst_tag   = acc_prev ? cur_tag : 20'($urandom);
    flush_i    = 1'b0;
    if (flush_now) begin flush_i = 1'b1; flush_now = 0; end
    if (flush_at_beat1 && beat_idx == 1 && beats_left == 3) begin
      flush_i = 1'b1; flush_at_beat1 = 0;
    end
    if (flush_prob > 0 && int'($urandom_range(0, 99)) < flush_prob) flush_i = 1'b1;
    inst_wr    = 1'b0;
    inst_size  = 2'b11;
    inst_wdata = $urandom;
    #1;
    if (!inst_req || flush_i) check("idx_ok_gated", inst_index_ok, 0);
    if (hold_prev) begin
      check("mreq_hold", mem_rd_req, 1);
      check("maddr_hold", mem_rd_addr, prev_addr);
    end
    if (flush_i && pend_valid && !inst_data_ok && cyc > pend_acc) begin
      pend_killed = 1;
      if (cyc == pend_acc + 1) pend_no_mem = 1;
    end
    if (mem_rd_req) begin
      check("mreq_owner", pend_valid && !pend_no_mem && !pend_mem_done, 1);
      if (mem_rd_addr_ok) begin
        check("mem_addr", mem_rd_addr, pend_addr);
        pend_mem_done = 1; mreq_active = 0;
        beats_left = 4; beat_idx = 0; mem_base = mem_rd_addr; hs_cyc = cyc;
      end
    end
    hold_prev = mem_rd_req && !mem_rd_addr_ok;
    prev_addr = mem_rd_addr;
    if (mem_rd_valid) begin
      beat_idx++; beats_left--;
      if (beats_left == 0) last_beat_cyc = cyc;
    end
    if (inst_data_ok) begin
      check("resp_live", pend_valid && !pend_killed, 1);
      check("rdata", inst_rdata, expected_line(pend_addr));
      check("resp_timing", cyc, last_beat_cyc + 1);
      resp_cnt++; last_lat = cyc - pend_acc; last_rdata = inst_rdata; pend_valid = 0;
    end
    last_idx_ok = inst_index_ok;
    if (inst_index_ok) begin
      check("accept_free", busy(), 0);
      if (inst_data_ok) b2b_hits++;
      cur_tag = use_fixed_tag ? fixed_tag : 20'($urandom);
      pend_valid = 1; pend_killed = 0; pend_no_mem = 0; pend_mem_done = 0;
      pend_addr = {cur_tag, inst_index, 4'b0000};
      pend_acc = cyc; last_acc_cyc = cyc; acc_cnt++;
      if (req_left > 0) req_left--;
      if (auto_inc) next_index++;
    end
    acc_prev = inst_index_ok;
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_resp(input int target, input int budget);
    int n = 0;
    while (resp_cnt < target && n < budget) begin cycle(); n++; end
    check("resp_timeout", resp_cnt >= target, 1);
  endtask

  task automatic run_until_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin cycle(); n++; end
    check("acc_timeout", acc_cnt >= target, 1);
  endtask

  initial begin
    int base, b;
    int n;
    // Reset state, with a request already presented.
    rst = 1'b0; inst_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_idx_ok", inst_index_ok, 0);
    check("rst_data_ok", inst_data_ok, 0);
    check("rst_mreq", mem_rd_req, 0);
    check("rst_maddr", mem_rd_addr, 0);
    check("rst_rdata", inst_rdata, 0);
    rst = 1'b1; inst_req = 1'b0;

    // Single fetch, zero-wait memory.
    next_index = 8'h3A; use_fixed_tag = 1; fixed_tag = 20'hBFC00; req_left = 1;
    run_until_resp(1, 40);
    check("t1_lat", last_lat, 7);
    check("t1_mreq_cyc", hs_cyc - last_acc_cyc, 2);
    check("t1_addr", mem_base, 32'hBFC003A0);
    check("t1_line", last_rdata, expected_line(32'hBFC003A0));
    use_fixed_tag = 0;

    // Slow address accept and a gap between beats.
    addr_delay_cfg = 3; gap_once = 1; next_index = 8'h5C; base = resp_cnt; req_left = 1;
    run_until_resp(base + 1, 60);
    check("t2_addr_wait", hs_cyc - last_acc_cyc, 5);
    run(10);
    check("t2_one_resp", resp_cnt - base, 1);
    addr_delay_cfg = 0;

    // Flush in the tag cycle; a new request rides the flush and is refused.
    base = resp_cnt; next_index = 8'h21; req_left = 1;
    run_until_acc(acc_cnt + 1, 20);
    flush_now = 1; req_left = 1; next_index = 8'h22;
    cycle();
    check("t3_blocked", last_idx_ok, 0);
    cycle();
    check("t3_reaccept", last_idx_ok, 1);
    run_until_resp(base + 1, 40);
    run(5);
    check("t3_resp_cnt", resp_cnt - base, 1);

    // Flush after the first beat: line drained, no response.
    base = resp_cnt; next_index = 8'h44; req_left = 1; flush_at_beat1 = 1;
    run(20);
    check("t4_dropped", resp_cnt - base, 0);
    check("t4_drained", beats_left, 0);
    next_index = 8'h45; req_left = 1;
    run_until_resp(base + 1, 40);

    // Back-to-back requests with req held.
    base = resp_cnt; b = b2b_hits; next_index = 8'h10; auto_inc = 1; req_left = 2;
    run_until_resp(base + 2, 60);
    auto_inc = 0;
    check("t5_b2b", b2b_hits - b, 1);
    check("t5_last_addr", mem_base[11:4], 8'h11);

    // Asynchronous reset in the middle of the beats.
    next_index = 8'h66; req_left = 1; n = 0;
    while (!(beat_idx == 2 && beats_left == 2) && n < 50) begin cycle(); n++; end
    check("t6_in_beat", beat_idx == 2 && beats_left == 2, 1);
    @(negedge clk);
    inst_req = 1'b1; flush_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t6_idx_ok", inst_index_ok, 0);
    check("t6_data_ok", inst_data_ok, 0);
    check("t6_mreq", mem_rd_req, 0);
    check("t6_maddr", mem_rd_addr, 0);
    check("t6_rdata", inst_rdata, 0);
    pend_valid = 0; beats_left = 0; beat_idx = 0; mreq_active = 0; hold_prev = 0;
    acc_prev = 0; mem_rd_valid = 1'b0; mem_rd_addr_ok = 1'b0; req_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; inst_req = 1'b0;
    base = resp_cnt; next_index = 8'h77; req_left = 1;
    run_until_resp(base + 1, 40);
    check("t6_lat", last_lat, 7);

    // Random traffic with flushes and irregular memory timing.
    rand_req = 1; rand_mem = 1; gap_prob = 30; flush_prob = 8;
    run(500);
    rand_req = 0; flush_prob = 0; req_left = 0;
    run(40);
    check("rand_drained", pend_valid && !pend_killed, 0);
    check("rand_progress", resp_cnt > 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
